// File: rtl/scp_079_ctrl.sv
// scp_079 containment controller: classifies green/yellow/red status and runs the escalation FSM.
// Optional feature: define SCP_LOCKDOWN_EN to count breach entries and latch a sticky LOCKDOWN state.
module scp_079_ctrl #(
  parameter int TIMER_W       = 6,
  parameter int ALARM_N       = 3,
  parameter int OK_CYCLES     = 40,
  parameter int WARN_CYCLES   = 10,
  parameter int ATTACK_CYCLES = 30,
  parameter int HOLD_CYCLES   = 8,
  parameter int CLEAR_CYCLES  = 5,
  parameter int CHEAT_CYCLES  = 4,
  parameter int LOCK_THRESH   = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               green,
  input  logic               yellow,
  input  logic               red,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic [ALARM_N-1:0] alarm,
  output logic               cheat_out,
  output logic               lockdown
);

  typedef enum logic [2:0] {
    S_OK     = 3'd0,
    S_WARN   = 3'd1,
    S_ATTACK = 3'd2,
    S_BREACH = 3'd3,
    S_CHEAT  = 3'd4,
    S_LOCK   = 3'd5
  } state_t;

  localparam int T_MAX = (1 << TIMER_W) - 1;
  localparam logic [TIMER_W-1:0] OK_LAST    = TIMER_W'(OK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WARN_LAST  = TIMER_W'(WARN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ATK_LAST   = TIMER_W'(ATTACK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_V     = TIMER_W'(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CHEAT_LAST = TIMER_W'(CHEAT_CYCLES - 1);

  if (ALARM_N < 1 || OK_CYCLES < 1 || OK_CYCLES > T_MAX || WARN_CYCLES < 1 || WARN_CYCLES > T_MAX ||
      ATTACK_CYCLES < 1 || ATTACK_CYCLES > T_MAX || HOLD_CYCLES < 1 || HOLD_CYCLES > T_MAX ||
      CLEAR_CYCLES < 1 || CLEAR_CYCLES > T_MAX || CHEAT_CYCLES < 1 || CHEAT_CYCLES > T_MAX ||
      LOCK_THRESH < 1 || LOCK_THRESH > T_MAX) begin : g_bad_params
    $error("scp_079_ctrl: a duration is out of range for TIMER_W");
  end

  state_t             r_state, w_next, w_breach_dst;
  logic [TIMER_W-1:0] r_timer, r_red_run, r_green_run;
  logic [TIMER_W-1:0] w_timer_nxt, w_red_run_nxt, w_green_run_nxt;
  logic [ALARM_N-1:0] r_alarm, w_alarm_nxt;
  logic               r_cheat, r_lock, w_lock_next, w_changing;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

`ifdef SCP_LOCKDOWN_EN
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_THRESH - 1);
  logic [TIMER_W-1:0] r_breach_cnt;
  logic               w_breach_entry;

  // The entry that would make the count reach LOCK_THRESH diverts to LOCKDOWN.
  assign w_breach_dst   = (r_breach_cnt >= LOCK_LAST) ? S_LOCK : S_BREACH;
  assign w_breach_entry = (w_next == S_BREACH || w_next == S_LOCK) && w_changing;
  assign w_lock_next    = (w_next == S_LOCK);

  always_ff @(posedge clock) begin
    if (!reset_n)            r_breach_cnt <= '0;
    else if (w_breach_entry) r_breach_cnt <= sat_inc(r_breach_cnt);
  end
`else
  assign w_breach_dst = S_BREACH;
  assign w_lock_next  = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OK: begin
        if (red)                             w_next = w_breach_dst;
        else if (yellow)                     w_next = S_WARN;
        else if (green && r_timer == OK_LAST) w_next = S_ATTACK;
      end
      S_WARN: begin
        if (red)         w_next = w_breach_dst;
        else if (yellow) begin
          if (r_timer == WARN_LAST) w_next = w_breach_dst;
        end
        else if (green)  w_next = S_OK;
      end
      S_ATTACK: begin
        // Timeout outranks every input, including a cheat-arming green.
        if (r_timer == ATK_LAST) w_next = w_breach_dst;
        else if (red)            w_next = S_ATTACK;
        else if (yellow)         w_next = S_WARN;
        else if (green) begin
          if (r_red_run >= HOLD_V)   w_next = S_CHEAT;
          else if (r_red_run != '0)  w_next = S_OK;
        end
      end
      S_BREACH: begin
        if (green && !yellow && !red && r_green_run == CLEAR_LAST) w_next = S_OK;
      end
      S_CHEAT: begin
        if (r_timer == CHEAT_LAST) w_next = S_OK;
      end
      S_LOCK:  w_next = S_LOCK;
      default: w_next = S_OK;
    endcase
  end

  always_comb begin
    w_changing      = (w_next != r_state);
    w_timer_nxt     = w_changing ? '0 : sat_inc(r_timer);
    w_red_run_nxt   = '0;
    w_green_run_nxt = '0;
    // Run counters track strictly consecutive cycles of the dominant input.
    if (!w_changing && r_state == S_ATTACK && red)
      w_red_run_nxt = sat_inc(r_red_run);
    if (!w_changing && r_state == S_BREACH && green && !yellow && !red)
      w_green_run_nxt = sat_inc(r_green_run);
    case (w_next)
      S_WARN, S_ATTACK: w_alarm_nxt = ALARM_N'(1);
      S_BREACH, S_LOCK: w_alarm_nxt = '1;
      default:          w_alarm_nxt = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_OK;
      r_timer     <= '0;
      r_red_run   <= '0;
      r_green_run <= '0;
      r_alarm     <= '0;
      r_cheat     <= 1'b0;
      r_lock      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_timer     <= w_timer_nxt;
      r_red_run   <= w_red_run_nxt;
      r_green_run <= w_green_run_nxt;
      r_alarm     <= w_alarm_nxt;
      r_cheat     <= (w_next == S_CHEAT);
      r_lock      <= w_lock_next;
    end
  end

  assign state     = r_state;
  assign timer     = r_timer;
  assign alarm     = r_alarm;
  assign cheat_out = r_cheat;
  assign lockdown  = r_lock;

endmodule

// File: tb/tb_scp_079_ctrl.sv
// Bench for scp_079_ctrl: directed scenarios plus random input bursts against a behavioural model.
module tb_scp_079_ctrl;

  localparam int TIMER_W = 6;
  localparam int ALARM_N = 3;
  localparam int OK_C = 40, WARN_C = 10, ATK_C = 30, HOLD_C = 8, CLEAR_C = 5, CHEAT_C = 4, LOCK_T = 3;
  localparam int TMAX = (1 << TIMER_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0, green = 1'b0, yellow = 1'b0, red = 1'b0;
  logic [2:0] state;
  logic [TIMER_W-1:0] timer;
  logic [ALARM_N-1:0] alarm;
  logic cheat_out, lockdown;

  int n_checks = 0;
  int n_fail = 0;

  // behavioural model: dwell time, run lengths, breach history
  int m_state = 0, m_timer = 0, m_rrun = 0, m_grun = 0, m_breaches = 0;

  scp_079_ctrl #(
    .TIMER_W(TIMER_W), .ALARM_N(ALARM_N), .OK_CYCLES(OK_C), .WARN_CYCLES(WARN_C),
    .ATTACK_CYCLES(ATK_C), .HOLD_CYCLES(HOLD_C), .CLEAR_CYCLES(CLEAR_C),
    .CHEAT_CYCLES(CHEAT_C), .LOCK_THRESH(LOCK_T)
  ) dut (
    .clock(clk), .reset_n(reset_n), .green(green), .yellow(yellow), .red(red),
    .state(state), .timer(timer), .alarm(alarm), .cheat_out(cheat_out), .lockdown(lockdown)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int breach_target();
`ifdef SCP_LOCKDOWN_EN
    return (m_breaches + 1 >= LOCK_T) ? 5 : 3;
`else
    return 3;
`endif
  endfunction

  function automatic int sat(input int v);
    return (v >= TMAX) ? TMAX : v + 1;
  endfunction

  // Advance the model one clock using the rules of the escalation ladder.
  task automatic model_clock(input bit rst_n, input bit g, input bit y, input bit r);
    int nxt;
    string dom;
    if (!rst_n) begin
      m_state = 0; m_timer = 0; m_rrun = 0; m_grun = 0; m_breaches = 0;
      return;
    end
    dom = r ? "red" : (y ? "yellow" : (g ? "green" : "none"));
    nxt = m_state;
    if (m_state == 0) begin
      if (dom == "red") nxt = breach_target();
      else if (dom == "yellow") nxt = 1;
      else if (dom == "green" && m_timer + 1 == OK_C) nxt = 2;
    end else if (m_state == 1) begin
      if (dom == "red") nxt = breach_target();
      else if (dom == "yellow" && m_timer + 1 == WARN_C) nxt = breach_target();
      else if (dom == "green") nxt = 0;
    end else if (m_state == 2) begin
      if (m_timer + 1 == ATK_C) nxt = breach_target();
      else if (dom == "yellow") nxt = 1;
      else if (dom == "green" && m_rrun >= HOLD_C) nxt = 4;
      else if (dom == "green" && m_rrun > 0) nxt = 0;
    end else if (m_state == 3) begin
      if (dom == "green" && m_grun + 1 == CLEAR_C) nxt = 0;
    end else if (m_state == 4) begin
      if (m_timer + 1 == CHEAT_C) nxt = 0;
    end
    if (nxt != m_state) begin
      if (nxt == 3 || nxt == 5) m_breaches++;
      m_state = nxt; m_timer = 0; m_rrun = 0; m_grun = 0;
    end else begin
      m_timer = sat(m_timer);
      m_rrun  = (m_state == 2 && dom == "red") ? sat(m_rrun) : 0;
      m_grun  = (m_state == 3 && dom == "green") ? sat(m_grun) : 0;
    end
  endtask

  function automatic int exp_alarm(input int s);
    if (s == 1 || s == 2) return 1;
    if (s == 3 || s == 5) return (1 << ALARM_N) - 1;
    return 0;
  endfunction

  task automatic step(input bit rst_n, input bit g, input bit y, input bit r);
    @(negedge clk);
    reset_n = rst_n; green = g; yellow = y; red = r;
    @(posedge clk);
    model_clock(rst_n, g, y, r);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("timer", 32'(timer), 32'(m_timer));
    check("alarm", 32'(alarm), 32'(exp_alarm(m_state)));
    check("cheat_out", 32'(cheat_out), 32'(m_state == 4));
    check("lockdown", 32'(lockdown), 32'(m_state == 5));
  endtask

  task automatic repeat_step(input int n, input bit g, input bit y, input bit r);
    for (int i = 0; i < n; i++) step(1'b1, g, y, r);
  endtask

  task automatic to_attack();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < OK_C; i++) begin
      check("ok_timer_count", 32'(timer), 32'(i));
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int len, combo;
    bit g, y, r;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_alarm", 32'(alarm), 32'd0);

    // green run from OK launches the attack
    to_attack();
    check("t1_state", 32'(state), 32'd2);
    check("t1_timer", 32'(timer), 32'd0);
    check("t1_alarm", 32'(alarm), 32'b001);

    // long red hold then green: cheat for exactly CHEAT_C cycles
    repeat_step(12, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_cheat_state", 32'(state), 32'd4);
    check("t2_cheat_out", 32'(cheat_out), 32'd1);
    for (int i = 0; i < CHEAT_C - 1; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("t2_cheat_hold", 32'(cheat_out), 32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_back_ok", 32'(state), 32'd0);
    check("t2_cheat_low", 32'(cheat_out), 32'd0);
    check("t2_alarm", 32'(alarm), 32'd0);

    // short red burst then green: attack repelled
    to_attack();
    repeat_step(3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_state", 32'(state), 32'd0);
    check("t3_cheat", 32'(cheat_out), 32'd0);

    // attack timeout, breach clear, interrupted clear
    to_attack();
    repeat_step(ATK_C - 1, 1'b0, 1'b0, 1'b0);
    check("t4_pre_timeout", 32'(state), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_breach", 32'(state), 32'd3);
    check("t4_alarm", 32'(alarm), 32'b111);
    repeat_step(CLEAR_C, 1'b1, 1'b0, 1'b0);
    check("t4_cleared", 32'(state), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat_step(4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_no_clear_yellow", 32'(state), 32'd3);
    repeat_step(4, 1'b1, 1'b0, 1'b0);
    check("t4_run_restarted", 32'(state), 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_clear_after_restart", 32'(state), 32'd0);

    // sustained yellow escalates; red beats green
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_warn", 32'(state), 32'd1);
    repeat_step(WARN_C - 1, 1'b0, 1'b1, 1'b0);
    check("t5_warn_hold", 32'(state), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_breach", 32'(state), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_red_wins", 32'(state), 32'd3);

    // repeated breaches: lockdown when enabled, plain breach otherwise
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LOCK_T - 1; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      repeat_step(CLEAR_C, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef SCP_LOCKDOWN_EN
    check("t6_lock_state", 32'(state), 32'd5);
    check("t6_lock_flag", 32'(lockdown), 32'd1);
    repeat_step(10, 1'b1, 1'b0, 1'b0);
    check("t6_lock_sticky", 32'(state), 32'd5);
`else
    check("t6_no_lock_state", 32'(state), 32'd3);
    check("t6_no_lock_flag", 32'(lockdown), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_reset_state", 32'(state), 32'd0);
    check("t6_reset_timer", 32'(timer), 32'd0);
    check("t6_reset_alarm", 32'(alarm), 32'd0);
    check("t6_reset_lock", 32'(lockdown), 32'd0);

    // random bursts of held input combinations, with rare resets
    for (int b = 0; b < 250; b++) begin
      len   = $urandom_range(1, 14);
      combo = $urandom_range(0, 9);
      g = (combo <= 4) || combo == 8;
      y = (combo == 5) || combo == 8;
      r = (combo == 6) || combo == 9;
      if ($urandom_range(0, 60) == 0) step(1'b0, g, y, r);
      for (int i = 0; i < len; i++) step(1'b1, g, y, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
